// File: rtl/mode_select_fsm.sv
// mode_select_fsm
//   Turns two raw push buttons into the 4-bit mode code used by the top-level
//   mode decoder. Each button is synchronised, debounced and edge-detected.
//   The resulting press pulses step a five-entry ring
//   (Clock -> Stop_Watch -> Timer -> Ultra -> DHT) forward or backward. A
//   press that arrives while the active function is busy is held back until
//   the function is idle.
//
// Parameters
//   DEBOUNCE_CYC  stable cycles needed before a new button level is accepted (>= 2)
//   CNT_W         debounce counter width, 2**CNT_W > DEBOUNCE_CYC
//
// Ports
//   iClk       system clock
//   iRst       asynchronous active-high reset
//   iBtn_Next  raw "next mode" button, active-high, asynchronous
//   iBtn_Prev  raw "previous mode" button, active-high, asynchronous
//   iLock      active function busy; mode changes are deferred
//   oMode      0000 Clock, 0001 Stop_Watch, 0010 Timer, 0100 Ultra, 1000 DHT
//   oMode_Chg  one-cycle pulse in the cycle oMode takes a new value
//   oPending   a press is queued behind iLock
module mode_select_fsm #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iBtn_Next,
  input  logic       iBtn_Prev,
  input  logic       iLock,
  output logic [3:0] oMode,
  output logic       oMode_Chg,
  output logic       oPending
);

  typedef enum logic [2:0] {
    S_CLOCK = 3'd0,
    S_SW    = 3'd1,
    S_TIMER = 3'd2,
    S_ULTRA = 3'd3,
    S_DHT   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  // Bit 0 carries the Next button and bit 1 carries the Prev button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       level;
  logic [1:0]       level_d;
  logic [1:0]       press;
  logic [CNT_W-1:0] cnt [2];

  state_t state;
  state_t next_state;
  logic   pend_dir;
  logic   press_one;
  logic   press_dir;
  logic   step_dir;

  assign btn_raw = {iBtn_Prev, iBtn_Next};

  // Synchronise, debounce and edge-detect both buttons. The press pulse is
  // registered from the accepted level and its delayed copy, so a release
  // produces no pulse.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] != level[b]) begin
          if (cnt[b] == CNT_LAST) begin
            level[b] <= ~level[b];
            cnt[b]   <= '0;
          end else begin
            cnt[b] <= cnt[b] + CNT_W'(1);
          end
        end else begin
          cnt[b] <= '0;
        end
      end
    end
  end

  function automatic state_t step(input state_t s, input logic back);
    state_t r;
    case (s)
      S_CLOCK: r = back ? S_DHT   : S_SW;
      S_SW:    r = back ? S_CLOCK : S_TIMER;
      S_TIMER: r = back ? S_SW    : S_ULTRA;
      S_ULTRA: r = back ? S_TIMER : S_DHT;
      S_DHT:   r = back ? S_ULTRA : S_CLOCK;
      default: r = S_CLOCK;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] decode(input state_t s);
    logic [3:0] r;
    case (s)
      S_SW:    r = 4'b0001;
      S_TIMER: r = 4'b0010;
      S_ULTRA: r = 4'b0100;
      S_DHT:   r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Coincident Next and Prev pulses cancel each other. A queued request
  // always takes priority over a fresh press.
  always_comb begin
    press_one  = press[0] ^ press[1];
    press_dir  = press[1];
    step_dir   = oPending ? pend_dir : press_dir;
    next_state = step(state, step_dir);
  end

  // Mode FSM. A press that lands right after a mode change is dropped, so
  // oMode_Chg never stays high for two consecutive cycles.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= S_CLOCK;
      oMode     <= 4'b0000;
      oMode_Chg <= 1'b0;
      oPending  <= 1'b0;
      pend_dir  <= 1'b0;
    end else begin
      oMode_Chg <= 1'b0;
      if (state > S_DHT) begin
        state    <= S_CLOCK;
        oMode    <= 4'b0000;
        oPending <= 1'b0;
      end else if (oPending && !iLock) begin
        state     <= next_state;
        oMode     <= decode(next_state);
        oMode_Chg <= 1'b1;
        oPending  <= 1'b0;
      end else if (press_one && !oMode_Chg) begin
        if (iLock) begin
          if (!oPending) begin
            oPending <= 1'b1;
            pend_dir <= press_dir;
          end
        end else begin
          state     <= next_state;
          oMode     <= decode(next_state);
          oMode_Chg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mode_select_fsm.sv
// tb_mode_select_fsm
//   Directed table of button presses plus hand-written lock, bounce and reset
//   sequences, followed by random button/lock activity compared every cycle
//   against a behavioural model (ring index arithmetic, queued request flag).
module tb_mode_select_fsm;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic       clock;
  logic       reset;
  logic       btnNext;
  logic       btnPrev;
  logic       lockIn;
  logic [3:0] oMode;
  logic       oMode_Chg;
  logic       oPending;

  int vectors;
  int miscompares;

  mode_select_fsm #(
    .DEBOUNCE_CYC(DEB),
    .CNT_W       (3)
  ) dut (
    .iClk     (clock),
    .iRst     (reset),
    .iBtn_Next(btnNext),
    .iBtn_Prev(btnPrev),
    .iLock    (lockIn),
    .oMode    (oMode),
    .oMode_Chg(oMode_Chg),
    .oPending (oPending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: raw samples age through a two-deep history, a button
  // level is accepted after DEB consecutive disagreeing samples, and the
  // resulting press reaches the mode ring two edges later.
  logic [3:0] codes [5];
  logic [1:0] histA, histB, accLvl, pipeA, pipeB;
  int         run [2];
  int         mIdx;
  logic       mPend, mDir, mChg;

  task automatic modelReset();
    histA  = '0;
    histB  = '0;
    accLvl = '0;
    pipeA  = '0;
    pipeB  = '0;
    run[0] = 0;
    run[1] = 0;
    mIdx   = 0;
    mPend  = 1'b0;
    mDir   = 1'b0;
    mChg   = 1'b0;
  endtask

  task automatic modelStep(input logic [1:0] rawNow, input logic lk);
    logic [1:0] pr;
    logic [1:0] rose;
    logic       chgNow;
    pr   = pipeB;
    rose = '0;
    for (int b = 0; b < 2; b++) begin
      if (histB[b] != accLvl[b]) begin
        run[b]++;
        if (run[b] == DEB) begin
          accLvl[b] = ~accLvl[b];
          run[b]    = 0;
          rose[b]   = accLvl[b];
        end
      end else begin
        run[b] = 0;
      end
    end
    pipeB = pipeA;
    pipeA = rose;
    histB = histA;
    histA = rawNow;
    chgNow = 1'b0;
    if (mPend && !lk) begin
      mIdx   = mDir ? (mIdx + 4) % 5 : (mIdx + 1) % 5;
      mPend  = 1'b0;
      chgNow = 1'b1;
    end else if ((pr[0] != pr[1]) && !mChg) begin
      if (lk) begin
        if (!mPend) begin
          mPend = 1'b1;
          mDir  = pr[1];
        end
      end else begin
        mIdx   = pr[1] ? (mIdx + 4) % 5 : (mIdx + 1) % 5;
        chgNow = 1'b1;
      end
    end
    mChg = chgNow;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) modelReset();
    else modelStep({btnPrev, btnNext}, lockIn);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one press for 'hold' sampling edges, then watch a fixed window.
  task automatic applyStimulus(input logic nxt, input logic prv, input int hold,
                               output int chgCount, output int lat);
    btnNext  = nxt;
    btnPrev  = prv;
    chgCount = 0;
    lat      = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (oMode_Chg) begin
        chgCount++;
        if (lat < 0) lat = n - 1;
      end
      if (n == hold) begin
        btnNext = 1'b0;
        btnPrev = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic       nxt;
    logic       prv;
    int         hold;
    logic [3:0] expMode;
    int         expChg;
  } vec_t;

  vec_t vecs [9];
  int   bounce [15];

  initial begin
    int chgCount;
    int lat;
    vectors     = 0;
    miscompares = 0;
    codes       = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bounce      = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    vecs[0] = '{1'b1, 1'b0, 8, 4'b0001, 1};
    vecs[1] = '{1'b1, 1'b0, 8, 4'b0010, 1};
    vecs[2] = '{1'b1, 1'b0, 8, 4'b0100, 1};
    vecs[3] = '{1'b1, 1'b0, 8, 4'b1000, 1};
    vecs[4] = '{1'b1, 1'b0, 8, 4'b0000, 1};
    vecs[5] = '{1'b0, 1'b1, 8, 4'b1000, 1};
    vecs[6] = '{1'b0, 1'b1, 8, 4'b0100, 1};
    vecs[7] = '{1'b1, 1'b0, 3, 4'b0100, 0};
    vecs[8] = '{1'b1, 1'b1, 8, 4'b0100, 0};

    modelReset();
    reset   = 1'b1;
    btnNext = 1'b0;
    btnPrev = 1'b0;
    lockIn  = 1'b0;
    tick();
    tick();
    checkOutput("reset_mode", int'(oMode), 0);
    checkOutput("reset_chg", int'(oMode_Chg), 0);
    checkOutput("reset_pending", int'(oPending), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].nxt, vecs[i].prv, vecs[i].hold, chgCount, lat);
      checkOutput($sformatf("row%0d_mode", i), int'(oMode), int'(vecs[i].expMode));
      checkOutput($sformatf("row%0d_chg_count", i), chgCount, vecs[i].expChg);
      if (vecs[i].expChg == 1) checkOutput($sformatf("row%0d_latency", i), lat, LAT);
    end

    // Bounce train ending in a long stable high: exactly one step.
    chgCount = 0;
    for (int n = 0; n < 30; n++) begin
      btnNext = (n < 15) ? (bounce[n] != 0) : 1'b0;
      tick();
      if (oMode_Chg) chgCount++;
    end
    checkOutput("bounce_chg_count", chgCount, 1);
    checkOutput("bounce_mode", int'(oMode), 4'b1000);

    applyStimulus(1'b0, 1'b1, 8, chgCount, lat);
    checkOutput("prev_a_mode", int'(oMode), 4'b0100);
    applyStimulus(1'b0, 1'b1, 8, chgCount, lat);
    checkOutput("prev_b_mode", int'(oMode), 4'b0010);

    // Lock: first request (Next) wins, Prev is dropped.
    lockIn = 1'b1;
    applyStimulus(1'b1, 1'b0, 8, chgCount, lat);
    checkOutput("lock_next_chg", chgCount, 0);
    applyStimulus(1'b0, 1'b1, 8, chgCount, lat);
    checkOutput("lock_prev_chg", chgCount, 0);
    checkOutput("lock_pending", int'(oPending), 1);
    checkOutput("lock_mode", int'(oMode), 4'b0010);
    lockIn = 1'b0;
    tick();
    checkOutput("unlock_mode", int'(oMode), 4'b0100);
    checkOutput("unlock_chg", int'(oMode_Chg), 1);
    checkOutput("unlock_pending", int'(oPending), 0);
    tick();
    checkOutput("unlock_chg_single", int'(oMode_Chg), 0);

    // Reset while pending at DHT and mid-debounce of a held button.
    applyStimulus(1'b1, 1'b0, 8, chgCount, lat);
    checkOutput("pre_reset_mode", int'(oMode), 4'b1000);
    lockIn = 1'b1;
    applyStimulus(1'b1, 1'b0, 8, chgCount, lat);
    checkOutput("pre_reset_pending", int'(oPending), 1);
    btnNext = 1'b1;
    tick();
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_mode", int'(oMode), 0);
    checkOutput("async_reset_pending", int'(oPending), 0);
    lockIn = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    chgCount = 0;
    lat      = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (oMode_Chg) begin
        chgCount++;
        if (lat < 0) lat = n - 1;
      end
    end
    checkOutput("held_reset_chg_count", chgCount, 1);
    checkOutput("held_reset_latency", lat, LAT);
    checkOutput("held_reset_mode", int'(oMode), 4'b0001);
    btnNext = 1'b0;
    repeat (10) tick();

    // Random activity against the model.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 800; c++) begin
      tick();
      checkOutput($sformatf("random_c%0d", c), int'({oMode, oMode_Chg, oPending}),
                  int'({codes[mIdx], mChg, mPend}));
      if ($urandom_range(0, 5) == 0) btnNext = ~btnNext;
      if ($urandom_range(0, 5) == 0) btnPrev = ~btnPrev;
      if ($urandom_range(0, 11) == 0) lockIn = ~lockIn;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
